// File: rtl/lib_arbiter_pkg.sv
// Shared constants and event word layout for the pixel event arbiter.
// Defining TIMESTAMP_EN prepends a 16-bit cycle stamp to the event word.
package lib_arbiter_pkg;

  localparam int ROWS     = 16;
  localparam int COLS     = 16;
  localparam int POLARITY = 2;
  localparam int GRP      = 4;
  localparam int NGRP     = (ROWS / GRP) * (COLS / GRP);
  localparam int NPIX     = GRP * GRP;
  localparam int RW       = $clog2(ROWS);
  localparam int CW       = $clog2(COLS);
  localparam int GW       = $clog2(NGRP);
  localparam int PW       = $clog2(NPIX);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

`ifdef TIMESTAMP_EN
  localparam int TSW = 16;
  typedef struct packed {
    logic [TSW-1:0]      ts;
    logic [RW-1:0]       row;
    logic [CW-1:0]       col;
    logic [POLARITY-1:0] pol;
  } event_t;
`else
  typedef struct packed {
    logic [RW-1:0]       row;
    logic [CW-1:0]       col;
    logic [POLARITY-1:0] pol;
  } event_t;
`endif

  localparam int WIDTH = $bits(event_t);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request strictly after ptr_i, wrapping.
// N must be a power of two so the pointer arithmetic wraps for free.
module rr_arbiter #(
  parameter int N = 16
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand_s;
  logic [IW-1:0] idx_s;
  logic          hit_s;
  logic          any_s;

  always_comb begin
    any_s  = 1'b0;
    idx_s  = '0;
    cand_s = '0;
    hit_s  = 1'b0;
    for (int i = 1; i <= N; i++) begin
      cand_s = ptr_i + IW'(i);
      hit_s  = ~any_s & req_i[cand_s];
      idx_s  = hit_s ? cand_s : idx_s;
      any_s  = any_s | hit_s;
    end
  end

  assign idx_o = idx_s;
  assign any_o = any_s;
  assign gnt_o = any_s ? (N'(1) << idx_s) : '0;

endmodule

// File: rtl/pixel_arbiter_top.sv
// Two-tier round-robin event arbiter for a 16x16 pixel array (4x4 groups, then pixels).
// Build option: TIMESTAMP_EN adds a free-running 16-bit stamp to each event word.
module pixel_arbiter_top
  import lib_arbiter_pkg::*;
(
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic [ROWS-1:0][COLS-1:0][POLARITY-1:0]   set_i,
  output logic [ROWS-1:0][COLS-1:0]                 gnt_o,
  output logic                                      grp_release_o,
  output logic [WIDTH-1:0]                          data_out_o
);

  arb_state_t              state_q, state_d;
  logic [GW-1:0]           grp_ptr_q, grp_ptr_d;
  logic [GW-1:0]           lock_grp_q, lock_grp_d;
  logic [PW-1:0]           pix_ptr_q, pix_ptr_d;
  logic [ROWS-1:0][COLS-1:0] gnt_q, gnt_d;
  event_t                  data_q, data_d;
  logic                    rel_q, rel_d;
`ifdef TIMESTAMP_EN
  logic [TSW-1:0]          ts_q, ts_d;
`endif

  logic [NGRP-1:0][NPIX-1:0] pix_req_s;
  logic [NGRP-1:0]         grp_req_s, grp_gnt_s;
  logic [GW-1:0]           grp_idx_s, cur_grp_s;
  logic                    grp_any_s;
  logic [NPIX-1:0]         cur_req_s, pix_gnt_s;
  logic [PW-1:0]           pix_idx_s, pix_ptr_s;
  logic                    pix_any_s, rem_any_s;
  logic [RW-1:0]           row_s;
  logic [CW-1:0]           col_s;

  // A pixel granted last cycle is masked to hide the requester's clear latency.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int G = (r / GRP) * (COLS / GRP) + c / GRP;
      localparam int P = (r % GRP) * GRP + c % GRP;
      assign pix_req_s[G][P] = (|set_i[r][c]) & ~gnt_q[r][c];
    end
  end

  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    assign grp_req_s[g] = |pix_req_s[g];
  end

  rr_arbiter #(.N(NGRP)) u_grp_arb (
    .req_i (grp_req_s),
    .ptr_i (grp_ptr_q),
    .gnt_o (grp_gnt_s),
    .idx_o (grp_idx_s),
    .any_o (grp_any_s)
  );

  assign cur_grp_s = (state_q == ST_LOCK) ? lock_grp_q : grp_idx_s;
  assign pix_ptr_s = (state_q == ST_LOCK) ? pix_ptr_q : PW'(NPIX - 1);

  always_comb begin
    cur_req_s = '0;
    if (state_q == ST_LOCK) begin
      cur_req_s = pix_req_s[lock_grp_q];
    end else begin
      for (int g = 0; g < NGRP; g++) begin
        cur_req_s = cur_req_s | (pix_req_s[g] & {NPIX{grp_gnt_s[g]}});
      end
    end
  end

  rr_arbiter #(.N(NPIX)) u_pix_arb (
    .req_i (cur_req_s),
    .ptr_i (pix_ptr_s),
    .gnt_o (pix_gnt_s),
    .idx_o (pix_idx_s),
    .any_o (pix_any_s)
  );

  assign rem_any_s = |(cur_req_s & ~pix_gnt_s);
  assign row_s     = {cur_grp_s[3:2], pix_idx_s[3:2]};
  assign col_s     = {cur_grp_s[1:0], pix_idx_s[1:0]};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      grp_ptr_q  <= 4'd15;
      lock_grp_q <= 4'd0;
      pix_ptr_q  <= 4'd15;
    end else begin
      state_q    <= state_d;
      grp_ptr_q  <= grp_ptr_d;
      lock_grp_q <= lock_grp_d;
      pix_ptr_q  <= pix_ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grp_ptr_d  = grp_ptr_q;
    lock_grp_d = lock_grp_q;
    pix_ptr_d  = pix_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (grp_any_s && rem_any_s) begin
          state_d    = ST_LOCK;
          lock_grp_d = cur_grp_s;
          pix_ptr_d  = pix_idx_s;
        end else if (grp_any_s) begin
          grp_ptr_d = cur_grp_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCK: begin
        if (pix_any_s && rem_any_s) begin
          pix_ptr_d = pix_idx_s;
        end else begin
          state_d   = ST_IDLE;
          grp_ptr_d = lock_grp_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Release fires on the last grant of a group, or when a locked group went empty.
  always_comb begin
    gnt_d  = '0;
    data_d = '0;
    rel_d  = ((state_q == ST_LOCK) || pix_any_s) && !rem_any_s;
`ifdef TIMESTAMP_EN
    ts_d   = ts_q + 16'd1;
`endif
    if (pix_any_s) begin
      gnt_d[row_s][col_s] = 1'b1;
      data_d.row = row_s;
      data_d.col = col_s;
      data_d.pol = set_i[row_s][col_s];
`ifdef TIMESTAMP_EN
      data_d.ts  = ts_q;
`endif
    end else begin
      gnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      gnt_q  <= '0;
      data_q <= '0;
      rel_q  <= 1'b0;
`ifdef TIMESTAMP_EN
      ts_q   <= 16'd0;
`endif
    end else begin
      gnt_q  <= gnt_d;
      data_q <= data_d;
      rel_q  <= rel_d;
`ifdef TIMESTAMP_EN
      ts_q   <= ts_d;
`endif
    end
  end

  assign gnt_o         = gnt_q;
  assign data_out_o    = data_q;
  assign grp_release_o = rel_q;

endmodule

// File: tb/tb_pixel_arbiter_top.sv
// Directed + randomized bench for pixel_arbiter_top against a coordinate-level reference model.
module tb_pixel_arbiter_top;
  import lib_arbiter_pkg::*;

  logic                                    clk_i = 1'b0;
  logic                                    reset_i = 1'b0;
  logic [ROWS-1:0][COLS-1:0][POLARITY-1:0] set_i = '0;
  logic [ROWS-1:0][COLS-1:0]               gnt_o;
  logic                                    grp_release_o;
  logic [WIDTH-1:0]                        data_out_o;

  int checks = 0;
  int failures = 0;

  // Reference model state (plain coordinates, not RTL encoding)
  bit          m_locked;
  int          m_grp, m_gptr, m_pptr, m_pr, m_pc;
  bit          m_pv;
  logic [15:0] m_ts;
  logic [255:0]     e_gnt;
  logic [WIDTH-1:0] e_data;
  logic             e_rel;
  bit               e_valid;
  int               e_r, e_c;
  int               tally [16][16];
  bit               pend  [16][16];

  pixel_arbiter_top dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .set_i         (set_i),
    .gnt_o         (gnt_o),
    .grp_release_o (grp_release_o),
    .data_out_o    (data_out_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit eff(input int r, input int c);
    logic [3:0] r4, c4;
    r4 = r[3:0];
    c4 = c[3:0];
    return (set_i[r4][c4] != 2'b00) && !(m_pv && m_pr == r && m_pc == c);
  endfunction

  function automatic bit grp_pend(input int g, input bit ex, input int er, input int ec);
    for (int p = 0; p < 16; p++) begin
      int r, c;
      r = (g / 4) * 4 + p / 4;
      c = (g % 4) * 4 + p % 4;
      if (eff(r, c) && !(ex && r == er && c == ec)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_grp = 0; m_gptr = 15; m_pptr = 15;
    m_pv = 0; m_pr = 0; m_pc = 0; m_ts = 16'd0;
  endtask

  task automatic model_step();
    int cur, pptr, p;
    logic [1:0] pol;
    logic [3:0] r4, c4;
    e_gnt = '0; e_data = '0; e_rel = 1'b0; e_valid = 0; e_r = 0; e_c = 0;
    cur = -1;
    if (m_locked) cur = m_grp;
    else for (int k = 1; k <= 16; k++) begin
      int g;
      g = (m_gptr + k) % 16;
      if (cur < 0 && grp_pend(g, 0, 0, 0)) cur = g;
    end
    if (cur >= 0) begin
      pptr = m_locked ? m_pptr : 15;
      p = -1;
      for (int k = 1; k <= 16; k++) begin
        int pp;
        pp = (pptr + k) % 16;
        if (p < 0 && eff((cur / 4) * 4 + pp / 4, (cur % 4) * 4 + pp % 4)) p = pp;
      end
      if (p >= 0) begin
        e_r = (cur / 4) * 4 + p / 4;
        e_c = (cur % 4) * 4 + p % 4;
        e_valid = 1;
        e_gnt[e_r * 16 + e_c] = 1'b1;
        r4 = e_r[3:0];
        c4 = e_c[3:0];
        pol = set_i[r4][c4];
`ifdef TIMESTAMP_EN
        e_data = {m_ts, r4, c4, pol};
`else
        e_data = {r4, c4, pol};
`endif
        if (grp_pend(cur, 1, e_r, e_c)) begin
          m_locked = 1; m_grp = cur; m_pptr = p;
        end else begin
          e_rel = 1'b1; m_locked = 0; m_gptr = cur;
        end
      end else begin
        e_rel = 1'b1; m_locked = 0; m_gptr = cur;
      end
    end
    m_pv = e_valid; m_pr = e_r; m_pc = e_c;
    m_ts = m_ts + 16'd1;
  endtask

  task automatic step(input bit clr);
    logic [3:0] r4, c4;
    @(posedge clk_i);
    model_step();
    #1;
    check("gnt", 256'(gnt_o), e_gnt);
    check("data", 256'(data_out_o), 256'(e_data));
    check("release", 256'(grp_release_o), 256'(e_rel));
    check("onehot", 256'($countones(gnt_o) <= 1), 256'(1'b1));
    if (clr && e_valid) begin
      r4 = e_r[3:0];
      c4 = e_c[3:0];
      set_i[r4][c4] = 2'b00;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"}, 256'(gnt_o), 256'(0));
    check({tag, "_data"}, 256'(data_out_o), 256'(0));
    check({tag, "_rel"}, 256'(grp_release_o), 256'(0));
  endtask

  initial begin
    int budget, bad;
    model_reset();
    // Reset with every pixel requesting
    set_i = {(ROWS * COLS){2'b10}};
    #2 reset_i = 1'b1;
    #1 check_zero("rst_async");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      check_zero("rst_hold");
    end
    reset_i = 1'b0;
    set_i = '0;
    model_reset();

    // Single pixel (2,5)
    set_i[2][5] = 2'b10;
    step(1);
    check("ev25", 256'(data_out_o[9:0]), 256'(10'b0010_0101_10));
    check("ev25_rel", 256'(grp_release_o), 256'(1'b1));
    for (int i = 0; i < 3; i++) step(1);

    // Whole group 0, row-major order, release only with the last
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) set_i[4'(r)][4'(c)] = 2'b01;
    for (int i = 0; i < 16; i++) begin
      step(1);
      check("order", 256'({gnt_o[4'(i / 4)][4'(i % 4)], grp_release_o}), 256'({1'b1, i == 15}));
    end
    step(1);

    // Locked group whose requests are withdrawn
    set_i[0][0] = 2'b10;
    set_i[0][1] = 2'b11;
    step(0);
    set_i = '0;
    step(0);
    step(0);

    // Two groups, ordering across and inside groups
    set_i[0][0] = 2'b01;
    set_i[5][6] = 2'b10;
    set_i[4][4] = 2'b01;
    for (int i = 0; i < 4; i++) step(1);

    // Random full array, reset pulsed mid-stream
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        set_i[4'(r)][4'(c)] = ($urandom_range(0, 1) != 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    for (int i = 0; i < 8; i++) step(1);
    reset_i = 1'b1;
    #1 check_zero("mid_rst");
    @(posedge clk_i); #1;
    check_zero("mid_rst_hold");
    reset_i = 1'b0;
    model_reset();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        pend[r][c]  = (set_i[4'(r)][4'(c)] != 2'b00);
        tally[r][c] = 0;
      end
    budget = 600;
    while (set_i != '0 && budget > 0) begin
      step(1);
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++)
          if (gnt_o[4'(r)][4'(c)]) tally[r][c]++;
      budget--;
    end
    check("drain_timeout", 256'(set_i != '0), 256'(0));
    bad = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        if (tally[r][c] != (pend[r][c] ? 1 : 0)) bad++;
    check("grant_once", 256'(bad), 256'(0));

    // Long idle, then one request (stamp reflects elapsed cycles when enabled)
    set_i = '0;
    for (int i = 0; i < 20; i++) step(1);
    set_i[15][15] = 2'b11;
    step(1);
    step(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
